// File: rtl/acsp_pkg.sv
// Shared types for the logic-analyzer capture/readback sequencer.
package acsp_pkg;

    localparam int SAMPLE_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        POST,
        RD_ADDR,
        RD_WAIT,
        SEND,
        TX_WAIT
    } capture_state_t;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_SEND,
        HS_WAIT_HI,
        HS_WAIT_LO
    } handshake_state_t;

endpackage

// File: rtl/tx_byte_handshake.sv
// Hands one byte to the UART: waits for idle, pulses tx_start, then waits for
// the busy high/low cycle that marks the byte as gone.
module tx_byte_handshake (
    input  logic       clock,
    input  logic       reset,
    input  logic       abort,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    output logic       byte_done
);
    import acsp_pkg::*;

    handshake_state_t hs_state, hs_next;
    logic start_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hs_state <= HS_IDLE;
            tx_start <= 1'b0;
            tx_byte  <= '0;
        end else begin
            hs_state <= hs_next;
            tx_start <= start_next;
            if (hs_state == HS_IDLE && load && !abort)
                tx_byte <= load_byte;
        end
    end

    always_comb begin
        hs_next    = hs_state;
        start_next = 1'b0;
        byte_done  = 1'b0;
        case (hs_state)
            HS_IDLE:    if (load) hs_next = HS_SEND;
            HS_SEND: begin
                if (!tx_busy) begin
                    start_next = 1'b1;
                    hs_next    = HS_WAIT_HI;
                end
            end
            HS_WAIT_HI: if (tx_busy) hs_next = HS_WAIT_LO;
            HS_WAIT_LO: begin
                if (!tx_busy) begin
                    byte_done = 1'b1;
                    hs_next   = HS_IDLE;
                end
            end
            default:    hs_next = HS_IDLE;
        endcase
        if (abort) begin
            hs_next    = HS_IDLE;
            start_next = 1'b0;
            byte_done  = 1'b0;
        end
    end

endmodule

// File: rtl/capture_sequencer.sv
// Circular capture into external sample RAM, post-trigger fill, then oldest-first
// readback of the most recent samples over the UART byte handshake.
module capture_sequencer #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cmd_arm,
    input  logic                    cmd_abort,
    input  logic [ADDR_WIDTH:0]     read_count,
    input  logic [ADDR_WIDTH:0]     delay_count,
    input  logic                    valid_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    run,
    output logic                    arm,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_waddr,
    output logic [SAMPLE_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH-1:0]   mem_raddr,
    input  logic [SAMPLE_WIDTH-1:0] mem_rdata,
    output logic [7:0]              tx_byte,
    output logic                    tx_start,
    input  logic                    tx_busy,
    output logic                    busy,
    output logic                    done
);
    import acsp_pkg::*;

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

    capture_state_t state, state_next;
    logic [ADDR_WIDTH-1:0] wptr, rptr;
    logic [CW-1:0] rc, dc, post_cnt, remaining;
    logic done_next, load, byte_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            rc        <= '0;
            dc        <= '0;
            post_cnt  <= '0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
            if (mem_we)
                wptr <= wptr + ADDR_WIDTH'(1);
            if (state == IDLE && state_next == ARMED) begin
                rc <= (read_count > DEPTH_C) ? DEPTH_C : read_count;
                dc <= delay_count;
            end
            if (state == ARMED && state_next == POST)
                post_cnt <= dc;
            else if (state == POST && valid_in)
                post_cnt <= post_cnt - CW'(1);
            // The final write increments wptr on the same edge, so the oldest
            // sample to return sits at (wptr + 1) - rc.
            if ((state == ARMED || state == POST) && state_next == RD_ADDR) begin
                rptr      <= wptr + ADDR_WIDTH'(1) - rc[ADDR_WIDTH-1:0];
                remaining <= rc;
            end else if (state == TX_WAIT && byte_done && !cmd_abort) begin
                rptr      <= rptr + ADDR_WIDTH'(1);
                remaining <= remaining - CW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        load       = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE:    if (cmd_arm) state_next = ARMED;
            ARMED: begin
                if (valid_in) begin
                    mem_we = 1'b1;
                    if (run) state_next = (dc == '0) ? RD_ADDR : POST;
                end
            end
            POST: begin
                if (valid_in) begin
                    mem_we = 1'b1;
                    if (post_cnt == CW'(1)) state_next = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (remaining == '0) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                load       = 1'b1;
                state_next = SEND;
            end
            SEND:    if (!tx_busy) state_next = TX_WAIT;
            TX_WAIT: begin
                if (byte_done) begin
                    if (remaining == CW'(1)) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = RD_ADDR;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (cmd_abort) begin
            state_next = IDLE;
            done_next  = 1'b0;
            load       = 1'b0;
        end
    end

    assign arm       = (state == ARMED);
    assign busy      = (state != IDLE);
    assign mem_waddr = wptr;
    assign mem_wdata = mem_we ? sample_in : '0;
    assign mem_raddr = rptr;

    tx_byte_handshake u_handshake (
        .clock     (clock),
        .reset     (reset),
        .abort     (cmd_abort),
        .load      (load),
        .load_byte (mem_rdata),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_byte   (tx_byte),
        .byte_done (byte_done)
    );

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer with a 16-entry RAM and a simple UART busy model.
module tb_capture_sequencer;

    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_arm = 1'b0;
    logic          cmd_abort = 1'b0;
    logic [AW:0]   read_count = '0;
    logic [AW:0]   delay_count = '0;
    logic          valid_in = 1'b0;
    logic [7:0]    sample_in = '0;
    logic          run = 1'b0;
    logic          arm;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [7:0]    mem_rdata;
    logic [7:0]    tx_byte;
    logic          tx_start;
    logic          tx_busy = 1'b0;
    logic          busy;
    logic          done;

    capture_sequencer #(.SAMPLE_WIDTH(8), .ADDR_WIDTH(AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_arm     (cmd_arm),
        .cmd_abort   (cmd_abort),
        .read_count  (read_count),
        .delay_count (delay_count),
        .valid_in    (valid_in),
        .sample_in   (sample_in),
        .run         (run),
        .arm         (arm),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .tx_byte     (tx_byte),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_cnt = 0, done_cnt = 0, start_cnt = 0, unstable = 0;
    int done_cyc = 0, start_cyc = 0, last_write_cyc = 0;
    int busy_len = 3, busy_left = 0;
    logic [7:0] held = '0;
    logic [7:0] bytes[$];
    logic [7:0] ram[16];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_we) ram[mem_waddr] <= mem_wdata;
        mem_rdata <= ram[mem_raddr];
    end

    // UART model and event monitor, evaluated mid-cycle
    always @(negedge clock) begin
        if (mem_we) we_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (tx_start) begin
            start_cnt++;
            start_cyc = cyc;
            bytes.push_back(tx_byte);
            held = tx_byte;
            tx_busy = 1'b1;
            busy_left = busy_len;
        end else if (tx_busy) begin
            if (tx_byte !== held) unstable++;
            busy_left--;
            if (busy_left <= 0) tx_busy = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic arm_cmd(input int rc, input int dc);
        cmd_arm = 1'b1;
        read_count = (AW+1)'(rc);
        delay_count = (AW+1)'(dc);
        tick();
        cmd_arm = 1'b0;
    endtask

    task automatic write_sample(input logic [7:0] d, input logic r);
        valid_in = 1'b1;
        sample_in = d;
        run = r;
        last_write_cyc = cyc;
        tick();
        valid_in = 1'b0;
        run = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base, input int limit);
        for (int n = 0; n < limit && done_cnt == base; n++) tick();
        check(tag, done_cnt, base + 1);
    endtask

    task automatic check_byte(input string tag, input int idx, input logic [7:0] exp);
        logic [31:0] got;
        got = (idx < bytes.size()) ? {24'h0, bytes[idx]} : 32'hDEAD;
        check(tag, got, {24'h0, exp});
    endtask

    int b0, s0, d0, w0;

    initial begin
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_outs", {arm, mem_we, tx_start, done}, 0);
        check("rst_waddr", mem_waddr, 0);
        check("rst_txbyte", tx_byte, 0);
        reset = 1'b0;
        tick();
        check("idle_raddr", mem_raddr, 0);

        // Abort beats a simultaneous arm
        cmd_abort = 1'b1;
        arm_cmd(4, 2);
        cmd_abort = 1'b0;
        check("arm_abort_busy", busy, 0);

        // 1: rc=4 dc=2, trigger on 0x15; a second arm while busy is ignored
        b0 = bytes.size(); s0 = start_cnt; d0 = done_cnt; w0 = we_cnt;
        arm_cmd(4, 2);
        check("t1_arm", arm, 1);
        check("t1_busy", busy, 1);
        arm_cmd(1, 0);
        for (int i = 0; i < 16; i++) write_sample(8'h10 + 8'(i), i == 5);
        wait_done("t1_done", d0, 300);
        check("t1_writes", we_cnt - w0, 8);
        check("t1_waddr", mem_waddr, 8);
        check("t1_starts", start_cnt - s0, 4);
        for (int k = 0; k < 4; k++) check_byte("t1_byte", b0 + k, 8'h14 + 8'(k));
        tick();
        check("t1_idle", busy, 0);
        check("t1_one_done", done_cnt - d0, 1);

        // 2: dc=0 rc=1, trigger on 0xA5, first tx_start four cycles after trigger write
        b0 = bytes.size(); s0 = start_cnt; d0 = done_cnt;
        arm_cmd(1, 0);
        write_sample(8'h01, 1'b0);
        write_sample(8'h02, 1'b0);
        write_sample(8'hA5, 1'b1);
        wait_done("t2_done", d0, 100);
        check("t2_starts", start_cnt - s0, 1);
        check_byte("t2_byte", b0, 8'hA5);
        check("t2_latency", start_cyc - last_write_cyc, 4);

        // 3: wrap across DEPTH, read_count above DEPTH clamps to 16
        busy_len = 2;
        b0 = bytes.size(); s0 = start_cnt; d0 = done_cnt;
        arm_cmd(20, 0);
        for (int i = 0; i < 21; i++) write_sample(8'h40 + 8'(i), i == 20);
        wait_done("t3_done", d0, 800);
        check("t3_starts", start_cnt - s0, 16);
        for (int k = 0; k < 16; k++) check_byte("t3_byte", b0 + k, 8'h45 + 8'(k));

        // 4: rc=0 pulses done one cycle after RD_ADDR, no transmit
        s0 = start_cnt; d0 = done_cnt;
        arm_cmd(0, 0);
        write_sample(8'h99, 1'b1);
        wait_done("t4_done", d0, 20);
        check("t4_latency", done_cyc - last_write_cyc, 2);
        check("t4_starts", start_cnt - s0, 0);

        // 5: abort during TX_WAIT of the second of five bytes
        busy_len = 3;
        b0 = bytes.size(); s0 = start_cnt; d0 = done_cnt;
        arm_cmd(5, 0);
        for (int i = 0; i < 5; i++) write_sample(8'h31 + 8'(i), i == 4);
        for (int n = 0; n < 100 && start_cnt - s0 < 2; n++) tick();
        tick();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        check("t5_idle", busy, 0);
        check("t5_txstart_low", tx_start, 0);
        repeat (40) tick();
        check("t5_starts", start_cnt - s0, 2);
        check("t5_no_done", done_cnt - d0, 0);
        check_byte("t5_byte0", b0, 8'h31);
        check_byte("t5_byte1", b0 + 1, 8'h32);
        arm_cmd(1, 0);
        check("t5_rearm", arm, 1);
        write_sample(8'h77, 1'b1);
        wait_done("t5_done2", d0, 100);
        check_byte("t5_byte_after", b0 + 2, 8'h77);

        // 6: long busy, one start per byte and stable tx_byte
        busy_len = 50;
        b0 = bytes.size(); s0 = start_cnt; d0 = done_cnt; unstable = 0;
        arm_cmd(3, 1);
        write_sample(8'h61, 1'b0);
        write_sample(8'h62, 1'b1);
        write_sample(8'h63, 1'b0);
        wait_done("t6_done", d0, 400);
        check("t6_starts", start_cnt - s0, 3);
        check("t6_stable", unstable, 0);
        for (int k = 0; k < 3; k++) check_byte("t6_byte", b0 + k, 8'h61 + 8'(k));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
